// File: rtl/mesm6_alu_seq_if.sv
// rtl/mesm6_alu_seq_if.sv - request, ALU and response bundle for the mesm6 ALU sequencer
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif
`ifndef ALU_NOP_B
`define ALU_NOP_B 1
`endif
`ifndef ALU_AND
`define ALU_AND 2
`endif
`ifndef ALU_ADD
`define ALU_ADD 3
`endif

interface mesm6_alu_seq_if #(
    parameter int OP_W = `ALU_OP_WIDTH
) ();
    // control unit request side
    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] req_op;
    logic [47:0]     req_b;
    logic            abort;

    // ALU side
    logic [47:0]     alu_a;
    logic [47:0]     alu_b;
    logic [OP_W-1:0] alu_op;
    logic [47:0]     alu_r;
    logic [47:0]     alu_y;
    logic            alu_done;

    // architectural registers and completion
    logic [47:0]     acc;
    logic [47:0]     y;
    logic            rsp_valid;
    logic            err;

    // master: the sequencer itself
    modport master (
        input  req_valid, req_op, req_b, abort, alu_r, alu_y, alu_done,
        output req_ready, alu_a, alu_b, alu_op, acc, y, rsp_valid, err
    );

    // slave: control unit plus ALU surrounding the sequencer
    modport slave (
        output req_valid, req_op, req_b, abort, alu_r, alu_y, alu_done,
        input  req_ready, alu_a, alu_b, alu_op, acc, y, rsp_valid, err
    );
endinterface

// File: rtl/mesm6_alu_seq.sv
// rtl/mesm6_alu_seq.sv - ALU initiator owning ACC and Y, with timeout and abort
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif

module mesm6_alu_seq #(
    parameter int          OP_W    = `ALU_OP_WIDTH,
    parameter int          TIMEOUT = 64,
    parameter logic [47:0] ACC_RST = 48'h0
) (
    input logic              clk,
    input logic              reset,
    mesm6_alu_seq_if.master  bus
);
    typedef enum logic {IDLE, EXEC} state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [OP_W-1:0]  OP_NOP   = OP_W'(`ALU_NOP);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [47:0]       acc_q;
    logic [47:0]       y_q;
    logic [47:0]       b_q;
    logic [OP_W-1:0]   op_q;
    logic              rsp_q;
    logic              err_q;

    // alu_a is ACC itself, so the A operand is frozen for the whole EXEC phase
    assign bus.req_ready = (state == IDLE);
    assign bus.alu_a     = acc_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.acc       = acc_q;
    assign bus.y         = y_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.err       = err_q;

    // accept/execute sequencer; abort beats done, done beats timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc_q <= ACC_RST;
            y_q   <= 48'h0;
            b_q   <= 48'h0;
            op_q  <= OP_NOP;
            rsp_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rsp_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        b_q   <= bus.req_b;
                        cnt   <= '0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.abort) begin
                        op_q  <= OP_NOP;
                        state <= IDLE;
                    end else if (bus.alu_done) begin
                        acc_q <= bus.alu_r;
                        y_q   <= bus.alu_y;
                        rsp_q <= 1'b1;
                        op_q  <= OP_NOP;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err_q <= 1'b1;
                        op_q  <= OP_NOP;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesm6_alu_seq.sv
// tb/tb_mesm6_alu_seq.sv - directed scoreboard bench for mesm6_alu_seq
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif
`ifndef ALU_NOP_B
`define ALU_NOP_B 1
`endif
`ifndef ALU_AND
`define ALU_AND 2
`endif
`ifndef ALU_ADD
`define ALU_ADD 3
`endif

module tb_mesm6_alu_seq;
    localparam int OP_W = `ALU_OP_WIDTH;
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(`ALU_NOP);
    localparam logic [OP_W-1:0] OP_NOP_B = OP_W'(`ALU_NOP_B);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(`ALU_AND);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(`ALU_ADD);

    typedef struct {
        logic [47:0] acc;
        logic [47:0] y;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    exp_t mon_e;

    // ALU stub controls
    int          lat;
    int          exec_cnt;
    logic [47:0] alu_y_m;

    mesm6_alu_seq_if #(.OP_W(OP_W)) bus ();

    mesm6_alu_seq #(.OP_W(OP_W), .TIMEOUT(8), .ACC_RST(48'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] alu_fn(input logic [OP_W-1:0] op, input logic [47:0] a, input logic [47:0] b);
        case (op)
            OP_NOP_B: alu_fn = b;
            OP_AND:   alu_fn = a & b;
            OP_ADD:   alu_fn = a + b;
            default:  alu_fn = 48'h0;
        endcase
    endfunction

    // ALU stub: lat==1 is a combinational ALU, lat==0 never finishes
    always @(posedge clk) exec_cnt <= bus.req_ready ? 0 : exec_cnt + 1;
    assign bus.alu_r    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_y    = alu_y_m;
    assign bus.alu_done = (lat == 1) ? 1'b1 : ((lat > 1) && (exec_cnt == lat - 1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [47:0] b);
        chk("accept_ready", 64'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = OP_AND;
        bus.req_b     = 48'hFFFF_FFFF_FFFF;
    endtask

    // response monitor: every rsp_valid retires the oldest expected result
    always @(posedge clk) begin
        #1;
        if (bus.rsp_valid) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_acc", 64'(bus.acc), 64'(mon_e.acc));
                chk("sb_y", 64'(bus.y), 64'(mon_e.y));
            end
            chk("rsp_err_excl", 64'(bus.err), 0);
        end
    end

    initial begin
        int k;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        lat           = 1;
        alu_y_m       = 48'h111;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_NOP;
        bus.req_b     = 48'h0;
        bus.abort     = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_acc", 64'(bus.acc), 0);
        chk("rst_y", 64'(bus.y), 0);
        chk("rst_ready", 64'(bus.req_ready), 1);
        chk("rst_op", 64'(bus.alu_op), 64'(OP_NOP));
        chk("rst_b", 64'(bus.alu_b), 0);
        chk("rst_rsp", 64'(bus.rsp_valid), 0);
        chk("rst_err", 64'(bus.err), 0);
        reset = 1'b0;
        tick();

        // single-cycle NOP_B: accept in N, rsp and new acc in N+2
        sb.push_back('{acc: 48'h0000_1234_5678, y: 48'h111});
        issue(OP_NOP_B, 48'h0000_1234_5678);
        chk("n1_ready", 64'(bus.req_ready), 0);
        chk("n1_op", 64'(bus.alu_op), 64'(OP_NOP_B));
        chk("n1_b", 64'(bus.alu_b), 64'h0000_1234_5678);
        chk("n1_a", 64'(bus.alu_a), 0);
        chk("n1_rsp", 64'(bus.rsp_valid), 0);
        tick();
        chk("n2_rsp", 64'(bus.rsp_valid), 1);
        chk("n2_acc", 64'(bus.acc), 64'h0000_1234_5678);
        chk("n2_ready", 64'(bus.req_ready), 1);
        chk("n2_op", 64'(bus.alu_op), 64'(OP_NOP));
        chk("idle_b_held", 64'(bus.alu_b), 64'h0000_1234_5678);

        // single-cycle AND against the new ACC
        alu_y_m = 48'h222;
        sb.push_back('{acc: 48'h0000_0000_5600, y: 48'h222});
        issue(OP_AND, 48'h0000_0000_FF00);
        tick();
        chk("and_acc", 64'(bus.acc), 64'h5600);
        tick();
        chk("rsp_one_cycle", 64'(bus.rsp_valid), 0);

        // 5-cycle ADD: operands stable, not ready, writeback at 5th EXEC edge
        lat     = 5;
        alu_y_m = 48'hABC;
        sb.push_back('{acc: 48'h0000_0000_5610, y: 48'hABC});
        issue(OP_ADD, 48'h10);
        for (int i = 0; i < 5; i++) begin
            chk("mc_ready", 64'(bus.req_ready), 0);
            chk("mc_op", 64'(bus.alu_op), 64'(OP_ADD));
            chk("mc_b", 64'(bus.alu_b), 64'h10);
            chk("mc_rsp", 64'(bus.rsp_valid), 0);
            bus.req_valid = 1'b1;
            tick();
            bus.req_valid = 1'b0;
        end
        chk("mc_done_rsp", 64'(bus.rsp_valid), 1);
        chk("mc_acc", 64'(bus.acc), 64'h5610);
        chk("mc_y", 64'(bus.y), 64'hABC);
        tick();

        // timeout: err after 8 EXEC cycles, no writeback
        lat = 0;
        issue(OP_ADD, 48'h1);
        k = 0;
        while (!bus.err && k < 20) begin
            tick();
            k++;
        end
        chk("to_cycles", 64'(k), 8);
        chk("to_err", 64'(bus.err), 1);
        chk("to_ready", 64'(bus.req_ready), 1);
        chk("to_acc", 64'(bus.acc), 64'h5610);
        chk("to_rsp", 64'(bus.rsp_valid), 0);
        tick();
        chk("to_err_pulse", 64'(bus.err), 0);

        // abort in the 3rd EXEC cycle of a 5-cycle op
        lat = 5;
        issue(OP_ADD, 48'h7);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_ready", 64'(bus.req_ready), 1);
        chk("ab_rsp", 64'(bus.rsp_valid), 0);
        chk("ab_err", 64'(bus.err), 0);
        chk("ab_op", 64'(bus.alu_op), 64'(OP_NOP));
        repeat (4) tick();
        chk("ab_acc", 64'(bus.acc), 64'h5610);

        // abort coincident with done
        lat = 1;
        issue(OP_ADD, 48'h1);
        chk("abd_done", 64'(bus.alu_done), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abd_rsp", 64'(bus.rsp_valid), 0);
        chk("abd_ready", 64'(bus.req_ready), 1);
        chk("abd_acc", 64'(bus.acc), 64'h5610);

        // abort in IDLE does not block an accept
        alu_y_m   = 48'h333;
        bus.abort = 1'b1;
        sb.push_back('{acc: 48'h77, y: 48'h333});
        issue(OP_NOP_B, 48'h77);
        bus.abort = 1'b0;
        chk("abi_accepted", 64'(bus.req_ready), 0);
        tick();
        chk("abi_acc", 64'(bus.acc), 64'h77);

        // back-to-back with req_valid held: accepts at cycles 0, 2, 4
        alu_y_m       = 48'h5A5;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ADD;
        bus.req_b     = 48'h1;
        for (int c = 0; c < 6; c++) begin
            chk("b2b_ready", 64'(bus.req_ready), 64'((c % 2) == 0));
            if ((c % 2) == 0) sb.push_back('{acc: 48'h78 + 48'(c / 2), y: 48'h5A5});
            if (c == 5) bus.req_valid = 1'b0;
            tick();
        end
        chk("b2b_acc", 64'(bus.acc), 64'h7A);

        // asynchronous reset in the middle of EXEC
        lat = 5;
        issue(OP_ADD, 48'h100);
        tick();
        reset = 1'b1;
        #1;
        chk("ar_ready", 64'(bus.req_ready), 1);
        chk("ar_acc", 64'(bus.acc), 0);
        chk("ar_y", 64'(bus.y), 0);
        chk("ar_op", 64'(bus.alu_op), 64'(OP_NOP));
        chk("ar_rsp", 64'(bus.rsp_valid), 0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("ar_acc_after", 64'(bus.acc), 0);
        chk("sb_drained", 64'(sb.size()), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mesm6_alu_seq.md
Name: mesm6_alu_seq

Overview:
- Initiator side of the mesm6 ALU interface.
- Owns the accumulator (ACC) and the Y register (least-significant bits).
- Accepts one operation request from the control unit, drives `alu_a`, `alu_b` and `alu_op` to the ALU, and holds them stable until the ALU raises `done`.
- On `done`, writes the ALU result into ACC and Y and reports completion. Supports single-cycle and multicycle ALU operations, a timeout, and a synchronous abort.

Parameters:
- OP_W, `ALU_OP_WIDTH, width of the ALU opcode.
- TIMEOUT, 64, number of EXEC cycles without `done` before the request is dropped with an error.
- ACC_RST, 48'h0, reset value of ACC.

Ports:
- clk  in  1  system clock; all registers on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  high when a request can be accepted (IDLE).
- req_op  in  OP_W  ALU opcode for the request.
- req_b  in  48  B operand (memory word or offset).
- abort  in  1  synchronous cancel of the in-flight operation.
- alu_a  out  48  A operand to the ALU; always equals ACC.
- alu_b  out  48  B operand to the ALU.
- alu_op  out  OP_W  opcode to the ALU.
- alu_r  in  48  ALU result.
- alu_y  in  48  ALU least-significant bits.
- alu_done  in  1  ALU completion.
- acc  out  48  accumulator.
- y  out  48  Y register.
- rsp_valid  out  1  one-cycle pulse: ACC and Y were updated.
- err  out  1  one-cycle pulse: timeout; ACC and Y unchanged.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, acc=ACC_RST, y=0.
  - alu_b=0, alu_op=`ALU_NOP.
  - rsp_valid=0, err=0, timeout counter=0.
- States: IDLE, EXEC.
- IDLE:
  - req_ready=1; alu_op=`ALU_NOP; alu_b holds its last value.
  - Accept when req_valid&&req_ready: latch req_op into alu_op and req_b into alu_b, clear the counter, go to EXEC.
- EXEC:
  - req_ready=0; alu_op and alu_b are held stable from registers.
  - alu_done is sampled at each rising edge, starting with the first EXEC cycle. A combinational ALU's `done` therefore completes in 1 EXEC cycle.
  - alu_done=1: acc<=alu_r, y<=alu_y, rsp_valid<=1, go to IDLE.
  - alu_done=0: increment the counter. When the counter reaches TIMEOUT-1 without done: err<=1, go to IDLE, no writeback.
- Latency: accept in cycle N; for a 1-cycle op the writeback happens at the end of cycle N+1.
  - rsp_valid is high in cycle N+2, the same cycle the new acc is visible.
  - req_ready is high again in cycle N+2, so the next request can be accepted in N+2.
- alu_a always equals the current acc. An operation in flight therefore uses the ACC value present at accept; ACC cannot change during EXEC.
- abort:
  - In EXEC: go to IDLE, no writeback, no rsp_valid, no err.
  - abort together with alu_done in the same cycle: abort wins.
  - In IDLE: abort has no effect, and a request presented with it is still accepted.
- rsp_valid and err are mutually exclusive and never high for more than one cycle.
- req_op and req_b are ignored outside the accept cycle.
- Counter width is $clog2(TIMEOUT+1); it does not wrap.

Test Plan:
- Reset, then release: acc=0, y=0, req_ready=1, alu_op=`ALU_NOP, rsp_valid=0.
- Single-cycle op (ALU tied to done=1): acc=0; issue `ALU_NOP_B` with b=48'h0000_1234_5678 → rsp_valid in cycle N+2, acc=48'h0000_1234_5678. Then issue `ALU_AND` with b=48'h0000_0000_FF00 → acc=48'h0000_0000_5600.
- Multicycle op (ALU model asserts done after 5 cycles): alu_op and alu_b stable for all 5 EXEC cycles, req_ready=0 throughout → writeback at the 5th EXEC edge, y=alu_y model value 48'hABC.
- Timeout with TIMEOUT=8 and done held 0 → err pulses exactly once after 8 EXEC cycles, acc unchanged, req_ready=1 the same cycle as err.
- Abort:
  - abort in the 3rd EXEC cycle of a 5-cycle op → IDLE, no rsp_valid, acc unchanged.
  - abort coincident with done → no writeback.
- Back-to-back requests with req_valid held high: accepts in cycles 0, 2, 4. Asynchronous reset asserted mid-EXEC → immediate IDLE, acc=ACC_RST, no rsp_valid.
